// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - shared instruction-memory request/ack bus
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem handshake, IF/ID latch
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  input  logic               stall,
  input  logic               mem_busy,
  fetch_stage_if.master      imem,
  output logic [15:0]        id_instruction,
  output logic [15:0]        id_pc_plus2,
  output logic               id_valid,
  output logic               fetch_busy
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t      state, stateNext;
  logic [15:0] pc, pcNext;
  logic [15:0] skidInstr, skidInstrNext;
  logic [15:0] skidPcPlus2, skidPcPlus2Next;
  logic [15:0] idInstrNext, idPcPlus2Next;
  logic        idValidNext;
  logic [15:0] pcPlus2;
  logic        xfer;

  assign pcPlus2        = pc + 16'd2;
  assign imem.imem_req  = (state == REQ) && !mem_busy;
  assign imem.imem_addr = pc;
  assign xfer           = imem.imem_req && imem.imem_ack;
  assign fetch_busy     = (state == REQ) && !xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      skidInstr      <= '0;
      skidPcPlus2    <= '0;
      id_instruction <= NOP_INSTR;
      id_pc_plus2    <= RESET_PC;
      id_valid       <= 1'b0;
    end else begin
      state          <= stateNext;
      pc             <= pcNext;
      skidInstr      <= skidInstrNext;
      skidPcPlus2    <= skidPcPlus2Next;
      id_instruction <= idInstrNext;
      id_pc_plus2    <= idPcPlus2Next;
      id_valid       <= idValidNext;
    end
  end

  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    skidInstrNext   = skidInstr;
    skidPcPlus2Next = skidPcPlus2;
    idInstrNext     = id_instruction;
    idPcPlus2Next   = id_pc_plus2;
    idValidNext     = id_valid;

    // A redirect flushes everything, including a word acked this same cycle.
    if (redirect) begin
      pcNext          = redirect_pc;
      idInstrNext     = NOP_INSTR;
      idValidNext     = 1'b0;
      skidInstrNext   = '0;
      skidPcPlus2Next = '0;
      stateNext       = REQ;
    end else begin
      case (state)
        BOOT: stateNext = REQ;
        REQ: begin
          if (xfer) begin
            pcNext = pcPlus2;
            if (stall) begin
              skidInstrNext   = imem.imem_rdata;
              skidPcPlus2Next = pcPlus2;
              stateNext       = HOLD;
            end else begin
              idInstrNext   = imem.imem_rdata;
              idPcPlus2Next = pcPlus2;
              idValidNext   = 1'b1;
            end
          end else if (!stall) begin
            idInstrNext = NOP_INSTR;
            idValidNext = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            idInstrNext   = skidInstr;
            idPcPlus2Next = skidPcPlus2;
            idValidNext   = 1'b1;
            stateNext     = REQ;
          end
        end
        default: stateNext = BOOT;
      endcase
    end
  end

endmodule
